// File: rtl/fp_pkg.sv
// Shared widths and bus payload types for the FP add/sub normalization path.
// exception_handling consumes norm_bus_t as produced by fp_norm_stage.
package fp_pkg;

  localparam int unsigned MANT_W = 23;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned LZC_W  = 5;
  localparam int unsigned MAG_W  = MANT_W + 1;
  localparam int unsigned SUM_W  = MANT_W + 2;

  // Payload captured by the first register stage
  typedef struct packed {
    logic [SUM_W-1:0] sum_mant;
    logic [EXP_W-1:0] in_exp;
    logic             in_eop;
  } sum_bus_t;

  // Normalized result handed to exception_handling
  typedef struct packed {
    logic             ovf;
    logic [EXP_W-1:0] sel_exp;
    logic [LZC_W-1:0] lzc_shift;
    logic             eop;
    logic [MANT_W-1:0] norm_mant;
    logic             zero;
  } norm_bus_t;

endpackage

// File: rtl/fp_norm_stage_if.sv
// Upstream sum handshake plus downstream normalized-result handshake.
// master drives sums and accepts results; slave is the normalization stage.
interface fp_norm_stage_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  sum_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              in_eop;

  logic              out_valid;
  logic              out_ready;
  logic              ovf;
  logic [EXP_W-1:0]  sel_exp;
  logic [LZC_W-1:0]  lzc_shift;
  logic              eop;
  logic [MANT_W-1:0] norm_mant;
  logic              zero;

  modport master (
    output in_valid, sum_mant, in_exp, in_eop, out_ready,
    input  in_ready, out_valid, ovf, sel_exp, lzc_shift, eop, norm_mant, zero
  );

  modport slave (
    input  in_valid, sum_mant, in_exp, in_eop, out_ready,
    output in_ready, out_valid, ovf, sel_exp, lzc_shift, eop, norm_mant, zero
  );

endinterface

// File: rtl/lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input yields 24.
module lzc24
  import fp_pkg::*;
(
  input  logic [MAG_W-1:0] vec_i,
  output logic [LZC_W-1:0] lz_o
);

  // Ascending scan: the highest set bit is visited last and wins
  always_comb begin
    lz_o = LZC_W'(MAG_W);
    for (int i = 0; i < MAG_W; i++) begin
      if (vec_i[i]) lz_o = LZC_W'(MAG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_stage.sv
// Two-stage normalization of the aligned-mantissa sum with valid/ready
// backpressure; exponent adjustment is left to exception_handling.
module fp_norm_stage
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           n_rst,
  fp_norm_stage_if.slave bus
);

  logic      rdy_q;
  logic      s1_valid_q, s1_valid_d;
  logic      s2_valid_q, s2_valid_d;
  sum_bus_t  s1_q, s1_d;
  norm_bus_t s2_q, s2_d;
  norm_bus_t norm_c;

  logic              s1_adv_c;
  logic              s2_adv_c;
  logic              in_xfer_c;
  logic              ovf_c;
  logic              zero_c;
  logic [MAG_W-1:0]  mag_c;
  logic [LZC_W-1:0]  lz_c;
  logic [MANT_W-1:0] shifted_c;

  // Handshake: a stage advances when empty or when the stage after it advances
  assign s2_adv_c     = ~s2_valid_q | bus.out_ready;
  assign s1_adv_c     = ~s1_valid_q | s2_adv_c;
  assign bus.in_ready = rdy_q & s1_adv_c;
  assign in_xfer_c    = bus.in_valid & bus.in_ready;

  // Carry only means overflow on an effective add; on subtract bit 24 is ignored
  assign mag_c     = s1_q.sum_mant[MAG_W-1:0];
  assign ovf_c     = s1_q.in_eop & s1_q.sum_mant[SUM_W-1];
  assign zero_c    = (mag_c == '0) & ~ovf_c;
  assign shifted_c = MANT_W'(mag_c << lz_c);

  lzc24 u_lzc (
    .vec_i (mag_c),
    .lz_o  (lz_c)
  );

  always_comb begin
    norm_c           = '0;
    norm_c.ovf       = ovf_c;
    norm_c.sel_exp   = s1_q.in_exp;
    norm_c.eop       = s1_q.in_eop;
    norm_c.zero      = zero_c;
    norm_c.norm_mant = mag_c[MANT_W-1:0];
    if (ovf_c) begin
      norm_c.norm_mant = mag_c[MANT_W:1];
    end else if (zero_c) begin
      norm_c.lzc_shift = LZC_W'(MAG_W);
      norm_c.norm_mant = '0;
    end else if (!s1_q.in_eop) begin
      norm_c.lzc_shift = lz_c;
      norm_c.norm_mant = shifted_c;
    end
  end

  // Next-state: data loads only on a transfer, valids drop only when drained
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (s1_adv_c) s1_valid_d = in_xfer_c;
    if (in_xfer_c) begin
      s1_d.sum_mant = bus.sum_mant;
      s1_d.in_exp   = bus.in_exp;
      s1_d.in_eop   = bus.in_eop;
    end
    if (s2_adv_c) s2_valid_d = s1_valid_q;
    if (s2_adv_c && s1_valid_q) s2_d = norm_c;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.ovf       = s2_q.ovf;
  assign bus.sel_exp   = s2_q.sel_exp;
  assign bus.lzc_shift = s2_q.lzc_shift;
  assign bus.eop       = s2_q.eop;
  assign bus.norm_mant = s2_q.norm_mant;
  assign bus.zero      = s2_q.zero;

endmodule

// File: doc/fp_norm_stage.md
Name: fp_norm_stage

Overview:
- Pipelined normalization stage for the FP add/sub datapath.
- Sits directly upstream of exception_handling and produces its inputs: ovf, sel_exp, lzc_shift, eop, norm_mant.
- Accepts the raw aligned-mantissa sum from the adder stage, detects carry-out, counts leading zeros, left-shifts, and registers the result behind a valid/ready handshake.
- Two register stages with full backpressure.

Parameters:
- MANT_W, 23, fraction width; norm_mant width; sum_mant is MANT_W+2.
- EXP_W, 8, exponent width of sel_exp.
- LZC_W, 5, lzc_shift width; must satisfy 2**LZC_W > MANT_W+1.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents a sum
- in_ready  output  1  stage can accept this cycle
- sum_mant  input  25  [24]=carry, [23]=hidden, [22:0]=fraction
- in_exp  input  8  selected (larger) exponent
- in_eop  input  1  effective operation: 1=add, 0=subtract
- out_valid  output  1  result valid toward exception_handling
- out_ready  input  1  downstream accepts
- ovf  output  1  carry-out normalization occurred
- sel_exp  output  8  in_exp passed through
- lzc_shift  output  5  left-shift amount applied
- eop  output  1  in_eop passed through
- norm_mant  output  23  normalized fraction, hidden bit dropped
- zero  output  1  sum was exactly zero

Behaviour:
- Reset is asynchronous on n_rst low. All outputs, both stage valids and all data registers clear to 0. in_ready reads 1 one cycle after reset release.
- Reset mid-operation discards in-flight data; no partial output is produced.
- Transfers:
  - An input transfer occurs on a clk edge with in_valid & in_ready.
  - An output transfer occurs on a clk edge with out_valid & out_ready.
- Stage 1 (S1) registers sum_mant/in_exp/in_eop and computes:
  - ovf_c = in_eop & sum_mant[24].
  - lz_c = count of leading zeros in sum_mant[23:0], range 0..24.
  - If in_eop=0, bit 24 is ignored (it is don't-care).
- Stage 2 (S2) registers the outputs:
  - ovf=1: norm_mant = sum[23:1] (truncate LSB), lzc_shift=0.
  - else if in_eop=1: norm_mant = sum[22:0], lzc_shift=0. Add never needs a left shift.
  - else: shifted = sum[23:0] << lz; norm_mant = shifted[22:0]; lzc_shift = lz.
  - zero = (sum[23:0]==0) & ~ovf. When zero=1: lzc_shift=24, norm_mant=0.
  - sel_exp and eop are passed unchanged. Exponent adjustment is not done here; exception_handling owns it.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Handshake:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Outputs hold stable while out_valid & ~out_ready.
  - No transaction is lost or duplicated.
- Simultaneous events:
  - Input and output transfer in the same cycle with both stages full: pipeline shifts, and occupancy stays 2.
  - out_ready low with both stages full: in_ready=0.
  - Data registers load only on a transfer; valids drop only when drained.
- in_valid may deassert at any time. Data is sampled only on a transfer.

Decomposition:
- Package fp_pkg: MANT_W/EXP_W/LZC_W constants, typedef norm_bus_t {ovf, sel_exp, lzc_shift, eop, norm_mant, zero}. exception_handling consumes the same typedef.
- Sub-module lzc24: combinational 24-bit priority leading-zero counter, output 0..24. It is instantiated in S1.

Test Plan:
- eop=1, sum_mant=25'h1800000, in_exp=8'h80 -> 2 cycles later ovf=1, norm_mant=23'h400000, lzc_shift=0, sel_exp=8'h80, zero=0.
- eop=0, sum_mant=25'h0200000 -> ovf=0, lzc_shift=2, norm_mant=23'h000000, zero=0. Also eop=0, sum_mant=25'h0000001 -> lzc_shift=23, norm_mant=0.
- eop=0, sum_mant=0 -> zero=1, lzc_shift=24, norm_mant=0. Also eop=0, sum_mant=25'h1000000 -> ovf=0, zero=1 (bit 24 ignored).
- Backpressure:
  - Stream 5 back-to-back inputs with out_ready held 0 -> in_ready drops after 2 accepted and out_valid holds transaction 1 stable.
  - Release out_ready -> all 5 emerge in order, one per cycle, none lost.
- Mid-stream reset: pulse n_rst low asynchronously (off-edge) with both stages full -> out_valid=0 and all outputs 0 immediately; in_ready=1 after release; no stale output follows.
